// File: rtl/sub_pipe.sv
// Two-stage pipelined WIDTH-bit subtractor with magnitude / wrap / unsigned-saturate /
// signed-saturate result modes, status flags and a valid/ready handshake on both sides.
module sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             neg_o,
    output logic             ovf_o,
    output logic             zero_o
);

    typedef enum logic [1:0] {
        MODE_MAG  = 2'b00,
        MODE_WRAP = 2'b01,
        MODE_USAT = 2'b10,
        MODE_SSAT = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic             s1_valid_q;
    logic [WIDTH:0]   s1_sum_q, s1_sum_d;
    logic             s1_sovf_q, s1_sovf_d;
    mode_e            s1_mode_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s1_adv, s2_adv, accept;
    logic [WIDTH-1:0] res;
    logic             borrow;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv && !rst_i;
    assign accept     = in_valid_i && in_ready_o;

    // Carry out of a + ~b + 1 is the no-borrow indication.
    assign s1_sum_d  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign s1_sovf_d = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (s1_sum_d[WIDTH-1] != a_i[WIDTH-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_sovf_q  <= 1'b0;
            s1_mode_q  <= MODE_MAG;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sum_q  <= s1_sum_d;
                s1_sovf_q <= s1_sovf_d;
                s1_mode_q <= mode_e'(mode_i);
            end
        end
    end

    always_comb begin
        res    = s1_sum_q[WIDTH-1:0];
        borrow = !s1_sum_q[WIDTH];
        diff_d = res;
        neg_d  = borrow;
        ovf_d  = 1'b0;
        case (s1_mode_q)
            MODE_MAG:  if (borrow) diff_d = -res;
            MODE_WRAP: diff_d = res;
            MODE_USAT: begin
                if (borrow) begin
                    diff_d = '0;
                    ovf_d  = 1'b1;
                end
            end
            MODE_SSAT: begin
                // True sign of the infinite-precision result.
                neg_d = res[WIDTH-1] ^ s1_sovf_q;
                ovf_d = s1_sovf_q;
                if (s1_sovf_q) diff_d = neg_d ? SMIN : SMAX;
            end
            default: diff_d = res;
        endcase
        zero_d = (diff_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q <= diff_d;
                neg_q  <= neg_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign diff_o      = diff_q;
    assign neg_o       = neg_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_sub_pipe.sv
// Bench for sub_pipe: an 8-bit instance for directed/backpressure/reset scenarios and a
// 4-bit instance swept exhaustively under random handshake timing against an arithmetic model.
module tb_sub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv8, ir8, ov8, or8, n8, o8, z8;
    logic [7:0] a8, b8, d8;
    logic [1:0] m8;
    logic       iv4, ir4, ov4, or4, n4, o4, z4;
    logic [3:0] a4, b4, d4;
    logic [1:0] m4;

    int vecs = 0;
    int errs = 0;

    sub_pipe #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8),
        .a_i(a8), .b_i(b8), .mode_i(m8), .out_valid_o(ov8), .out_ready_i(or8),
        .diff_o(d8), .neg_o(n8), .ovf_o(o8), .zero_o(z8)
    );

    sub_pipe #(.WIDTH(4)) u4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv4), .in_ready_o(ir4),
        .a_i(a4), .b_i(b4), .mode_i(m4), .out_valid_o(ov4), .out_ready_i(or4),
        .diff_o(d4), .neg_o(n4), .ovf_o(o4), .zero_o(z4)
    );

    // Result of a w-bit operation computed with plain integer arithmetic,
    // packed as {diff, neg, ovf, zero}.
    function automatic logic [31:0] model(int w, int ua, int ub, int m);
        int dd, d, n, o, sa, sb, sd, lo, hi;
        dd = ua - ub;
        n  = (dd < 0) ? 1 : 0;
        o  = 0;
        case (m)
            0: d = (dd < 0) ? -dd : dd;
            1: d = dd & ((1 << w) - 1);
            2: begin d = (dd < 0) ? 0 : dd; o = n; end
            default: begin
                sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
                sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
                sd = sa - sb;
                lo = -(1 << (w - 1));
                hi = (1 << (w - 1)) - 1;
                o  = (sd < lo || sd > hi) ? 1 : 0;
                n  = (sd < 0) ? 1 : 0;
                d  = ((sd < lo) ? lo : (sd > hi) ? hi : sd) & ((1 << w) - 1);
            end
        endcase
        return 32'((d << 3) | (n << 2) | (o << 1) | ((d == 0) ? 1 : 0));
    endfunction

    task automatic test_reset();
        rst = 1'b1; iv8 = 1'b1; iv4 = 1'b1; or8 = 1'b1; or4 = 1'b1;
        a8 = 8'd3; b8 = 8'd10; m8 = 2'b00; a4 = 4'd1; b4 = 4'd2; m4 = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({ir8, ov8, d8, n8, o8, z8} !== 12'h0) begin
            errs++; $display("FAIL reset8: got ir/ov/diff/flags %b want all zero", {ir8, ov8, d8, n8, o8, z8});
        end
        vecs++;
        if ({ir4, ov4, d4, n4, o4, z4} !== 8'h0) begin
            errs++; $display("FAIL reset4: got ir/ov/diff/flags %b want all zero", {ir4, ov4, d4, n4, o4, z4});
        end
        @(posedge clk); #1;
        rst = 1'b0; iv8 = 1'b0; iv4 = 1'b0;
        @(negedge clk);
        vecs++;
        if ({ir8, ir4, ov8, ov4} !== 4'b1100) begin
            errs++; $display("FAIL reset_release: got ir8,ir4,ov8,ov4 %b want 1100", {ir8, ir4, ov8, ov4});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int ta[11] = '{3, 10, 3, 3, 10, 'h80, 'h7F, 'h05, 5, 0, 5};
        int tb[11] = '{10, 3, 10, 10, 3, 'h01, 'hFF, 'h07, 5, 'hFF, 5};
        int tm[11] = '{0, 0, 1, 2, 2, 3, 3, 3, 0, 0, 1};
        int te[11] = '{'h7, 'h7, 'hF9, 'h0, 'h7, 'h80, 'h7F, 'hFE, 'h0, 'hFF, 'h0};
        int tf[11] = '{4, 0, 4, 7, 0, 6, 2, 4, 1, 4, 1};   // {neg,ovf,zero}
        logic [10:0] want;
        or8 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            a8 = 8'(ta[i]); b8 = 8'(tb[i]); m8 = 2'(tm[i]); iv8 = 1'b1;
            @(negedge clk);
            vecs++;
            if (ir8 !== 1'b1) begin
                errs++; $display("FAIL dir%0d_in_ready: got %b want 1", i, ir8);
            end
            @(posedge clk); #1;
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 2'($urandom);
            @(negedge clk);
            vecs++;
            if (ov8 !== 1'b0) begin
                errs++; $display("FAIL dir%0d_early_valid: got %b want 0", i, ov8);
            end
            @(posedge clk); #1;
            @(negedge clk);
            want = {8'(te[i]), 3'(tf[i])};
            vecs++;
            if ({ov8, d8, n8, o8, z8} !== {1'b1, want}) begin
                errs++; $display("FAIL dir%0d_result: got valid=%b diff=%h nvz=%b want valid=1 diff=%h nvz=%b",
                                 i, ov8, d8, {n8, o8, z8}, want[10:3], want[2:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pa[5], pb[5];
        logic [1:0] pm[5];
        logic [10:0] held;
        logic [31:0] e;
        int idx = 0, ret = 0;
        bit acc, rt;
        for (int i = 0; i < 5; i++) begin
            pa[i] = 8'($urandom); pb[i] = 8'($urandom); pm[i] = 2'($urandom);
        end
        held = '0;
        for (int c = 0; c < 60 && ret < 5; c++) begin
            iv8 = (idx < 5);
            if (idx < 5) begin a8 = pa[idx]; b8 = pb[idx]; m8 = pm[idx]; end
            or8 = (c >= 6);
            @(negedge clk);
            if (c == 2) held = {d8, n8, o8, z8};
            if (c >= 2 && c <= 5) begin
                vecs++;
                if ({ir8, ov8, d8, n8, o8, z8} !== {2'b01, held}) begin
                    errs++; $display("FAIL bp_stall_c%0d: got ir=%b ov=%b out=%h want ir=0 ov=1 out=%h",
                                     c, ir8, ov8, {d8, n8, o8, z8}, held);
                end
            end
            acc = iv8 && ir8;
            rt  = ov8 && or8;
            if (rt) begin
                e = model(8, int'(pa[ret]), int'(pb[ret]), int'(pm[ret]));
                vecs++;
                if ({d8, n8, o8, z8} !== e[10:0]) begin
                    errs++; $display("FAIL bp_retire%0d: got %h want %h", ret, {d8, n8, o8, z8}, e[10:0]);
                end
                ret++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        iv8 = 1'b0;
        vecs++;
        if (ret != 5) begin
            errs++; $display("FAIL bp_timeout: got %0d retired want 5", ret);
        end
    endtask

    task automatic test_reset_midflight();
        or8 = 1'b0; iv8 = 1'b1; a8 = 8'd3; b8 = 8'd10; m8 = 2'b00;
        @(posedge clk); #1;
        a8 = 8'd10; b8 = 8'd3; m8 = 2'b10;
        @(posedge clk); #1;
        rst = 1'b1; a8 = 8'd1; b8 = 8'd2; m8 = 2'b01;
        @(negedge clk);
        vecs++;
        if ({ir8, ov8} !== 2'b01) begin
            errs++; $display("FAIL mid_before_rst: got ir,ov %b want 01", {ir8, ov8});
        end
        @(posedge clk); #1;
        rst = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        vecs++;
        if ({ir8, ov8, d8, n8, o8, z8} !== {2'b10, 11'h0}) begin
            errs++; $display("FAIL mid_after_rst: got ir/ov/diff/flags %b want 10 then zeros", {ir8, ov8, d8, n8, o8, z8});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vecs++;
            if (ov8 !== 1'b0) begin
                errs++; $display("FAIL mid_stale%0d: got out_valid %b want 0", i, ov8);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random4();
        logic [31:0] q[$];
        logic [31:0] e;
        int k = 0, got = 0;
        bit acc;
        for (int c = 0; c < 20000 && got < 1024; c++) begin
            iv4 = (k < 1024) && ($urandom_range(0, 3) != 0);
            a4 = 4'(k); b4 = 4'(k >> 4); m4 = 2'(k >> 8);
            or4 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = iv4 && ir4;
            if (acc) q.push_back(model(4, k & 15, (k >> 4) & 15, (k >> 8) & 3));
            if (ov4 && or4) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL rnd4_spurious: got result %h want none", {d4, n4, o4, z4});
                end else begin
                    e = q.pop_front();
                    if ({d4, n4, o4, z4} !== e[6:0]) begin
                        errs++; $display("FAIL rnd4_op%0d: got %h want %h", got, {d4, n4, o4, z4}, e[6:0]);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        iv4 = 1'b0; or4 = 1'b1;
        vecs++;
        if (got != 1024 || q.size() != 0) begin
            errs++; $display("FAIL rnd4_count: got %0d retired, %0d pending want 1024, 0", got, q.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++;
        if (ov4 !== 1'b0) begin
            errs++; $display("FAIL rnd4_drain: got out_valid %b want 0", ov4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random8();
        logic [31:0] q[$];
        logic [31:0] e;
        int k = 0, got = 0;
        bit acc;
        for (int c = 0; c < 5000 && got < 300; c++) begin
            if (!iv8 || !ir8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); m8 = 2'($urandom);
            end
            iv8 = (k < 300) && ($urandom_range(0, 2) != 0);
            or8 = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = iv8 && ir8;
            if (acc) q.push_back(model(8, int'(a8), int'(b8), int'(m8)));
            if (ov8 && or8) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL rnd8_spurious: got result %h want none", {d8, n8, o8, z8});
                end else begin
                    e = q.pop_front();
                    if ({d8, n8, o8, z8} !== e[10:0]) begin
                        errs++; $display("FAIL rnd8_op%0d: got %h want %h", got, {d8, n8, o8, z8}, e[10:0]);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        iv8 = 1'b0;
        vecs++;
        if (got != 300 || q.size() != 0) begin
            errs++; $display("FAIL rnd8_count: got %0d retired, %0d pending want 300, 0", got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random4();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
